// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - MIPS opcode/funct decode into ALU control, registered into a one-entry ID/EX stage
// Also tracks a saturating count of accepted illegal encodings.
module alu_ctrl_decode #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_control,
  output logic             alu_src_imm,
  output logic [31:0]      imm_ext,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       dest_reg,
  output logic             reg_write,
  output logic             is_branch,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  logic [3:0]  d_alu;
  logic        d_src_imm;
  logic [31:0] d_imm;
  logic [4:0]  d_dest;
  logic        d_reg_write;
  logic        d_branch;
  logic        d_illegal;

  logic        accept;
  logic        unused_shamt;

  assign opcode   = instr[31:26];
  assign f_rs     = instr[25:21];
  assign f_rt     = instr[20:16];
  assign f_rd     = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};

  // Shift amount is not used by any supported operation.
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    d_alu       = ALU_AND;
    d_src_imm   = 1'b0;
    d_imm       = imm_sext;
    d_dest      = 5'd0;
    d_reg_write = 1'b0;
    d_branch    = 1'b0;
    d_illegal   = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        d_dest      = f_rd;
        d_reg_write = 1'b1;
        unique case (funct)
          FN_ADDU: d_alu = ALU_ADD;
          FN_SUBU: d_alu = ALU_SUB;
          FN_AND:  d_alu = ALU_AND;
          FN_OR:   d_alu = ALU_OR;
          FN_NOR:  d_alu = ALU_NOR;
          FN_SLTU: d_alu = ALU_SLT;
          default: begin
            d_illegal   = 1'b1;
            d_dest      = 5'd0;
            d_reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDIU, OP_SLTIU, OP_LW: begin
        d_alu       = (opcode == OP_SLTIU) ? ALU_SLT : ALU_ADD;
        d_src_imm   = 1'b1;
        d_dest      = f_rt;
        d_reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        d_alu       = (opcode == OP_ORI) ? ALU_OR : ALU_AND;
        d_src_imm   = 1'b1;
        d_imm       = imm_zext;
        d_dest      = f_rt;
        d_reg_write = 1'b1;
      end
      OP_SW: begin
        d_alu     = ALU_ADD;
        d_src_imm = 1'b1;
      end
      OP_BEQ: begin
        d_alu    = ALU_SUB;
        d_branch = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_control <= 4'd0;
      alu_src_imm <= 1'b0;
      imm_ext     <= 32'd0;
      rs          <= 5'd0;
      rt          <= 5'd0;
      dest_reg    <= 5'd0;
      reg_write   <= 1'b0;
      is_branch   <= 1'b0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      alu_control <= d_alu;
      alu_src_imm <= d_src_imm;
      imm_ext     <= d_imm;
      rs          <= f_rs;
      rt          <= f_rt;
      dest_reg    <= d_dest;
      reg_write   <= d_reg_write;
      is_branch   <= d_branch;
      illegal     <= d_illegal;
      if (d_illegal && (illegal_cnt != CNT_MAX)) begin
        illegal_cnt <= illegal_cnt + CNT_ONE;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// tb/tb_alu_ctrl_decode.sv - directed vector bench for alu_ctrl_decode
module tb_alu_ctrl_decode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic        alu_src_imm;
  logic [31:0] imm_ext;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        is_branch;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  alu_ctrl_decode #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .alu_src_imm(alu_src_imm), .imm_ext(imm_ext),
    .rs(rs), .rt(rt), .dest_reg(dest_reg), .reg_write(reg_write),
    .is_branch(is_branch), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        src_imm;
    logic        chk_imm;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        rw;
    logic        br;
    logic        ill;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  int pass_cnt;
  int total_cnt;
  int exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " alu_control"}, {28'd0, alu_control}, {28'd0, v.alu});
    chk({tag, " alu_src_imm"}, {31'd0, alu_src_imm}, {31'd0, v.src_imm});
    if (v.chk_imm) chk({tag, " imm_ext"}, imm_ext, v.imm);
    chk({tag, " rs"}, {27'd0, rs}, {27'd0, v.rs});
    chk({tag, " rt"}, {27'd0, rt}, {27'd0, v.rt});
    chk({tag, " dest_reg"}, {27'd0, dest_reg}, {27'd0, v.dest});
    chk({tag, " reg_write"}, {31'd0, reg_write}, {31'd0, v.rw});
    chk({tag, " is_branch"}, {31'd0, is_branch}, {31'd0, v.br});
    chk({tag, " illegal"}, {31'd0, illegal}, {31'd0, v.ill});
    chk({tag, " illegal_cnt"}, {24'd0, illegal_cnt}, exp_cnt);
  endtask

  task automatic accept_one(input logic [31:0] ins);
    @(negedge clk);
    in_valid  = 1'b1;
    instr     = ins;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    //          instr          alu     src  chk  imm            rs  rt  dest rw br ill
    vecs[0]  = '{32'h00221821, 4'b0010, 0, 0, 32'h0,         1, 2, 3, 1, 0, 0};
    vecs[1]  = '{32'h00221823, 4'b0110, 0, 0, 32'h0,         1, 2, 3, 1, 0, 0};
    vecs[2]  = '{32'h00221824, 4'b0000, 0, 0, 32'h0,         1, 2, 3, 1, 0, 0};
    vecs[3]  = '{32'h00221825, 4'b0001, 0, 0, 32'h0,         1, 2, 3, 1, 0, 0};
    vecs[4]  = '{32'h00221827, 4'b1100, 0, 0, 32'h0,         1, 2, 3, 1, 0, 0};
    vecs[5]  = '{32'h0022182B, 4'b0111, 0, 0, 32'h0,         1, 2, 3, 1, 0, 0};
    vecs[6]  = '{32'h2422FFFF, 4'b0010, 1, 1, 32'hFFFFFFFF,  1, 2, 2, 1, 0, 0};
    vecs[7]  = '{32'h2C228001, 4'b0111, 1, 1, 32'hFFFF8001,  1, 2, 2, 1, 0, 0};
    vecs[8]  = '{32'h3022F0F0, 4'b0000, 1, 1, 32'h0000F0F0,  1, 2, 2, 1, 0, 0};
    vecs[9]  = '{32'h34228000, 4'b0001, 1, 1, 32'h00008000,  1, 2, 2, 1, 0, 0};
    vecs[10] = '{32'h8C850004, 4'b0010, 1, 1, 32'h00000004,  4, 5, 5, 1, 0, 0};
    vecs[11] = '{32'hAC850008, 4'b0010, 1, 1, 32'h00000008,  4, 5, 0, 0, 0, 0};
    vecs[12] = '{32'h10220003, 4'b0110, 0, 1, 32'h00000003,  1, 2, 0, 0, 1, 0};
    vecs[13] = '{32'h0022182A, 4'b0000, 0, 0, 32'h0,         1, 2, 0, 0, 0, 1};
    vecs[14] = '{32'h00221820, 4'b0000, 0, 0, 32'h0,         1, 2, 0, 0, 0, 1};
    vecs[15] = '{32'hFC000000, 4'b0000, 0, 0, 32'h0,         0, 0, 0, 0, 0, 1};
    vecs[16] = '{32'h00221821, 4'b0010, 0, 0, 32'h0,         1, 2, 3, 1, 0, 0};

    pass_cnt = 0;
    total_cnt = 0;
    exp_cnt = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    instr = 32'd0;
    flush = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
    chk("reset alu_control", {28'd0, alu_control}, 32'd0);
    chk("reset reg_write", {31'd0, reg_write}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      accept_one(vecs[i].instr);
      if (vecs[i].ill) exp_cnt++;
      chk_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back stream at full throughput
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    instr = vecs[0].instr;
    @(posedge clk); #1;
    chk_vec("stream1", vecs[0]);
    @(negedge clk);
    instr = vecs[1].instr;
    @(posedge clk); #1;
    chk_vec("stream2", vecs[1]);
    @(negedge clk);
    instr = vecs[6].instr;
    @(posedge clk); #1;
    chk_vec("stream3", vecs[6]);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure on a held BEQ
    accept_one(vecs[12].instr);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = vecs[0].instr;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk_vec($sformatf("stall%0d", c), vecs[12]);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_vec("release", vecs[0]);

    // Flush with a held entry and a same-cycle illegal input
    @(negedge clk);
    out_ready = 1'b0;
    flush = 1'b1;
    in_valid = 1'b1;
    instr = 32'hFC000000;
    @(posedge clk); #1;
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush illegal_cnt", {24'd0, illegal_cnt}, exp_cnt);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;

    // Saturation of the illegal counter
    for (int k = 0; k < 260; k++) begin
      accept_one(32'hFC000000);
      if (exp_cnt < 255) exp_cnt++;
    end
    chk("sat illegal_cnt", {24'd0, illegal_cnt}, 32'd255);
    chk_vec("sat", vecs[15]);

    // Asynchronous reset while holding an entry
    @(negedge clk);
    in_valid = 1'b1;
    instr = vecs[0].instr;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("prereset out_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("async reset illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
    chk("async reset dest_reg", {27'd0, dest_reg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
